// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and types
package uart_pkg;

    localparam int UART_RX_FIFO_DEPTH  = 16;
    localparam int UART_RX_FIFO_THRESH = 8;

    typedef logic [7:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receive FIFO push/pop/status bundle
interface uart_rx_fifo_if import uart_pkg::*; #(
    parameter int DEPTH = UART_RX_FIFO_DEPTH
) ();

    uart_byte_t               in_data;
    logic                     in_valid;
    logic                     rd;
    logic                     flush;
    logic                     clr_ovf;
    uart_byte_t               out_data;
    logic                     out_valid;
    logic [$clog2(DEPTH):0]   count;
    logic                     full;
    logic                     overflow;
    logic                     above_thresh;

    // Master side: receiver + CPU, driving pushes, pops and control.
    modport master (
        output in_data, in_valid, rd, flush, clr_ovf,
        input  out_data, out_valid, count, full, overflow, above_thresh
    );

    // Slave side: the FIFO itself.
    modport slave (
        input  in_data, in_valid, rd, flush, clr_ovf,
        output out_data, out_valid, count, full, overflow, above_thresh
    );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - generic first-word-fall-through queue with explicit count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     push_ok_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_eff;
    logic             push_acc;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    // A pop on a full queue always frees a slot, so a push is still safe.
    assign push_ok_o = ~full_o | pop_i;
    assign pop_eff   = pop_i & ~empty_o & ~flush_i;
    assign push_acc  = push_i & push_ok_o & ~flush_i;

    assign count_o = count_q;
    // Head is forced to zero when empty so the output is defined after reset.
    assign rdata_o = empty_o ? '0 : mem_q[rp_q];

    // Next pointers and occupancy; a concurrent push and pop leave count unchanged.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (flush_i) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (push_acc) wp_d = wp_q + AW'(1);
            if (pop_eff)  rp_d = rp_q + AW'(1);
            case ({push_acc, pop_eff})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wp_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive byte buffer with overflow and threshold flags
module uart_rx_fifo import uart_pkg::*; #(
    parameter int DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int THRESH = UART_RX_FIFO_THRESH
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_fifo_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          push_ok;
    logic          drop;
    logic          overflow_q, overflow_d;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (bus.in_valid),
        .pop_i     (bus.rd),
        .flush_i   (bus.flush),
        .wdata_i   (bus.in_data),
        .rdata_o   (bus.out_data),
        .count_o   (count),
        .full_o    (full),
        .empty_o   (empty),
        .push_ok_o (push_ok)
    );

    // A push is lost only when full with no pop; flush discards pushes without a drop.
    assign drop = bus.in_valid & ~push_ok & ~bus.flush;

    // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (drop)              overflow_d = 1'b1;
        else if (bus.clr_ovf)  overflow_d = 1'b0;
    end

    // Overflow register.
    always_ff @(posedge clk) begin
        if (rst) overflow_q <= 1'b0;
        else     overflow_q <= overflow_d;
    end

    assign bus.count        = count;
    assign bus.full         = full;
    assign bus.out_valid    = ~empty;
    assign bus.overflow     = overflow_q;
    assign bus.above_thresh = (count >= CW'(THRESH));

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH  = 16;
    localparam int THRESH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q [$];
    logic       m_ovf = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"}, 32'(bus.count), 32'(exp_q.size()));
        check({tag, ".full"}, 32'(bus.full), 32'(exp_q.size() == DEPTH));
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(exp_q.size() != 0));
        check({tag, ".above_thresh"}, 32'(bus.above_thresh), 32'(exp_q.size() >= THRESH));
        check({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
        if (exp_q.size() != 0)
            check({tag, ".head"}, 32'(bus.out_data), 32'(exp_q[0]));
    endtask

    // One clock of stimulus; the model decides acceptance and the scoreboard is checked after the edge.
    task automatic step(input string tag, input logic push, input logic [7:0] d,
                        input logic pop, input logic fl, input logic clr);
        logic was_full;
        logic pop_eff;
        bus.in_valid = push;
        bus.in_data  = d;
        bus.rd       = pop;
        bus.flush    = fl;
        bus.clr_ovf  = clr;
        if (fl) begin
            exp_q.delete();
        end else begin
            was_full = (exp_q.size() == DEPTH);
            pop_eff  = pop && (exp_q.size() != 0);
            if (pop_eff) begin
                check({tag, ".pop_data"}, 32'(bus.out_data), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
            if (push && (!was_full || pop_eff)) exp_q.push_back(d);
            if (push && was_full && !pop_eff) m_ovf = 1'b1;
            else if (clr)                     m_ovf = 1'b0;
        end
        tick();
        bus.in_valid = 1'b0;
        bus.rd       = 1'b0;
        bus.flush    = 1'b0;
        bus.clr_ovf  = 1'b0;
        check_state(tag);
    endtask

    task automatic do_reset(input logic push_during);
        rst          = 1'b1;
        bus.in_valid = push_during;
        bus.in_data  = 8'hEE;
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        m_ovf = 1'b0;
        check_state("reset");
        check("reset.out_data", 32'(bus.out_data), 32'h00);
    endtask

    initial begin
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.rd       = 1'b0;
        bus.flush    = 1'b0;
        bus.clr_ovf  = 1'b0;
        tick();
        do_reset(1'b0);

        // Single byte, visible one cycle after the push, then popped.
        step("single_push", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        step("single_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step("single_pop",  1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Order across the pointer wrap and threshold tracking.
        for (int i = 0; i < 16; i++) begin
            step("fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            step("fill_gap", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 16; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 16; i < 24; i++) step("wrap_push", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step("wrap_pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Overflow: a push into a full FIFO is dropped and flagged.
        for (int i = 0; i < 16; i++) step("ovf_fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        step("ovf_drop", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        step("ovf_clear", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Full with push and pop together; then a drop coinciding with clr_ovf.
        step("full_pushpop", 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        step("drop_vs_clr", 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step("drain2", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Empty with push and pop together: the byte stays.
        step("empty_pushpop", 1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        step("empty_pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Flush with a coincident push; overflow is still set from above.
        for (int i = 0; i < 5; i++) step("flush_fill", 1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
        step("flush", 1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
        step("post_flush", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);

        // Mid-operation reset with 10 entries and overflow set; byte during reset is lost.
        for (int i = 0; i < 9; i++) step("rst_fill", 1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b0);
        check("rst_pre.count", 32'(bus.count), 32'd10);
        check("rst_pre.overflow", 32'(bus.overflow), 32'd1);
        do_reset(1'b1);
        step("post_rst_push", 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        step("post_rst_pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
